// File: rtl/voq_islip_sched.sv
// Single-iteration packet-mode iSLIP scheduler: matches VOQ inputs to outputs.
// A matched pair stays locked until the tail word is popped.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module voq_islip_sched #(
  parameter int PORT_NUB  = `PORT_NUB_TOTAL,
  parameter int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUB*PORT_NUB-1:0]  empty_in,
  input  logic [PORT_NUB-1:0]           eop_in,
  input  logic [PORT_NUB-1:0]           full_in,
  output logic [PORT_NUB-1:0]           rd_out,
  output logic [PORT_NUB*WIDTH_SEL-1:0] rd_sel,
  output logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel,
  output logic [PORT_NUB-1:0]           wr_out,
  output logic [PORT_NUB-1:0]           busy_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} st_t;

  st_t                  st_q    [PORT_NUB];
  st_t                  st_d    [PORT_NUB];
  logic [WIDTH_SEL-1:0] lk_q    [PORT_NUB];
  logic [WIDTH_SEL-1:0] lk_d    [PORT_NUB];
  logic [WIDTH_SEL-1:0] gptr_q  [PORT_NUB];
  logic [WIDTH_SEL-1:0] gptr_d  [PORT_NUB];
  logic [WIDTH_SEL-1:0] aptr_q  [PORT_NUB];
  logic [WIDTH_SEL-1:0] aptr_d  [PORT_NUB];
  logic [PORT_NUB-1:0]  in_busy_q;
  logic [PORT_NUB-1:0]  in_busy_d;

  // Matrices indexed [output][input].
  logic [PORT_NUB-1:0]  emp [PORT_NUB];
  logic [PORT_NUB-1:0]  req [PORT_NUB];
  logic [PORT_NUB-1:0]  gnt [PORT_NUB];
  logic [PORT_NUB-1:0]  acc [PORT_NUB];
  logic [PORT_NUB-1:0]  in_acc;
  logic [PORT_NUB-1:0]  rd_o;

  function automatic logic [WIDTH_SEL-1:0] wrap_add(input logic [WIDTH_SEL-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= PORT_NUB) s = s - PORT_NUB;
    return s[WIDTH_SEL-1:0];
  endfunction

  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      for (int i = 0; i < PORT_NUB; i++) begin
        emp[o][i] = empty_in[o*PORT_NUB+i];
        req[o][i] = !in_busy_q[i] && !empty_in[o*PORT_NUB+i];
      end
    end
  end

  // Grant: first requester at or after gptr, only from a free, non-full output.
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      gnt[o] = '0;
      if (st_q[o] == ST_IDLE && !full_in[o]) begin
        for (int k = 0; k < PORT_NUB; k++) begin
          if (gnt[o] == '0 && req[o][wrap_add(gptr_q[o], k)])
            gnt[o][wrap_add(gptr_q[o], k)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_acc = '0;
    for (int o = 0; o < PORT_NUB; o++) acc[o] = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      for (int k = 0; k < PORT_NUB; k++) begin
        if (!in_acc[i] && gnt[wrap_add(aptr_q[i], k)][i]) begin
          acc[wrap_add(aptr_q[i], k)][i] = 1'b1;
          in_acc[i] = 1'b1;
        end
      end
    end
  end

  // rd_out is a pop strobe: the VOQ named by rd_sel pops its head at the next
  // clk edge; the popped word leaves RAM one cycle later, qualified by wr_out.
  always_comb begin
    rd_out = '0;
    rd_sel = '0;
    rd_o   = '0;
    for (int o = 0; o < PORT_NUB; o++) begin
      if (st_q[o] == ST_LOCK) begin
        rd_o[o] = !emp[o][lk_q[o]] && !full_in[o];
        for (int i = 0; i < PORT_NUB; i++) begin
          if (lk_q[o] == WIDTH_SEL'(i)) begin
            rd_out[i] = rd_o[o];
            rd_sel[i*WIDTH_SEL +: WIDTH_SEL] = WIDTH_SEL'(o);
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      st_d[o]   = st_q[o];
      lk_d[o]   = lk_q[o];
      gptr_d[o] = gptr_q[o];
      aptr_d[o] = aptr_q[o];
    end
    in_busy_d = in_busy_q;
    for (int o = 0; o < PORT_NUB; o++) begin
      if (st_q[o] == ST_LOCK) begin
        if (rd_o[o] && eop_in[lk_q[o]]) begin
          st_d[o] = ST_IDLE;
          in_busy_d[lk_q[o]] = 1'b0;
        end
      end else begin
        for (int i = 0; i < PORT_NUB; i++) begin
          if (acc[o][i]) begin
            st_d[o]      = ST_LOCK;
            lk_d[o]      = WIDTH_SEL'(i);
            gptr_d[o]    = wrap_add(WIDTH_SEL'(i), 1);
            aptr_d[i]    = wrap_add(WIDTH_SEL'(o), 1);
            in_busy_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUB; o++) begin
        st_q[o]   <= ST_IDLE;
        lk_q[o]   <= '0;
        gptr_q[o] <= '0;
        aptr_q[o] <= '0;
      end
      in_busy_q <= '0;
      wr_out    <= '0;
      mux_sel   <= '0;
    end else begin
      for (int o = 0; o < PORT_NUB; o++) begin
        st_q[o]   <= st_d[o];
        lk_q[o]   <= lk_d[o];
        gptr_q[o] <= gptr_d[o];
        aptr_q[o] <= aptr_d[o];
        if (st_q[o] == ST_LOCK) mux_sel[o*WIDTH_SEL +: WIDTH_SEL] <= lk_q[o];
      end
      in_busy_q <= in_busy_d;
      wr_out    <= rd_o;
    end
  end

  // busy_out is the per-output FSM state bit.
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) busy_out[o] = (st_q[o] == ST_LOCK);
  end

endmodule

// File: doc/voq_islip_sched.md
Name: voq_islip_sched

Overview:
- Packet-mode iSLIP scheduler (single iteration) for the shared-memory switch.
- It matches input ports to output ports, drives VOQ read enables and read selects on the input side, and drives crossbar mux selects and write enables on the output side.
- A matched input/output pair stays locked until the packet's tail word has been read, so packets are never interleaved at an output.
- It is an alternative to the fixed rotating TDM sequencer, for non-uniform traffic.

Parameters:
- PORT_NUB, default `PORT_NUB_TOTAL (4), number of input ports and number of output ports.
- WIDTH_SEL, default $clog2(PORT_NUB), width of one port index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- empty_in  in  PORT_NUB**2  bit o*PORT_NUB+i = VOQ(input i -> output o) empty.
- eop_in  in  PORT_NUB  bit i = head word of the VOQ currently selected by rd_sel[i] is a packet tail.
- full_in  in  PORT_NUB  bit o = output o FIFO full.
- rd_out  out  PORT_NUB  bit i = pop the VOQ on input i this cycle.
- rd_sel  out  PORT_NUB*WIDTH_SEL  field i = output index of the VOQ being popped on input i.
- mux_sel  out  PORT_NUB*WIDTH_SEL  field o = input index routed to output o.
- wr_out  out  PORT_NUB  bit o = write output o FIFO.
- busy_out  out  PORT_NUB  bit o = output o is locked to an input.

Behaviour:
- Per-output state:
  - st_o: IDLE or LOCK.
  - lk_o: locked input index.
  - gptr_o: grant pointer.
- Per-input state:
  - in_busy_i: input is locked.
  - aptr_i: accept pointer.
- Reset (asynchronous, immediate): all outputs 0, all st_o = IDLE, in_busy = 0, all pointers = 0. Reset mid-packet abandons the packet; no further rd_out or wr_out.
- Request: input i requests output o when !in_busy_i and !empty[o][i].
- Grant: output o with st_o = IDLE and !full_in[o] grants the requesting input at or after gptr_o, scanning upward modulo PORT_NUB.
- Accept:
  - Input i accepts the granting output at or after aptr_i, modulo PORT_NUB.
  - Request, grant and accept are combinational from registered state.
- On accept (at the clock edge):
  - st_o <= LOCK, lk_o <= i, in_busy_i <= 1.
  - gptr_o <= (i+1) mod PORT_NUB.
  - aptr_i <= (o+1) mod PORT_NUB.
  - Pointers are unchanged for unaccepted grants.
- Read, combinational:
  - In LOCK, rd_out[lk_o] = !empty[o][lk_o] & !full_in[o], and rd_sel field lk_o = o.
  - Unlocked inputs have rd_out = 0 and rd_sel = 0.
  - The first read occurs in the cycle after the accept edge.
- Write, registered, one cycle after the read (RAM read latency 1):
  - wr_out[o] <= rd_out[lk_o] when in LOCK, else 0.
  - mux_sel field o <= lk_o, and holds its value when idle.
- Release: a read with eop_in[lk_o] = 1 sets st_o <= IDLE and in_busy <= 0 at that edge.
  - The pair can request, grant and accept again in the next cycle; a release edge never also carries a new match for the same ports.
- Stalls:
  - An empty VOQ mid-packet, or full_in high, holds the lock with rd_out = 0.
  - No timeout.
- Simultaneous events: different free pairs can match in the same cycle that other pairs read or release.
- Width rules: pointer increments wrap modulo PORT_NUB. For non-power-of-2 PORT_NUB, index PORT_NUB-1 wraps to 0.
- busy_out[o] = (st_o == LOCK), registered.

Test Plan (PORT_NUB = 4):
- Single flow:
  - Stimulus: VOQ(1->2) holds 3 words, tail on word 3; all else empty.
  - Required: accept at cycle c; rd_out = 0010 with rd_sel[1] = 2 for cycles c+1..c+3; wr_out[2] high for c+2..c+4 with mux_sel[2] = 1; gptr_2 = 2, aptr_1 = 3; busy_out[2] clears after c+3.
- Output contention:
  - Stimulus: inputs 0, 1 and 3 each hold 1-word packets for output 0; gptr_0 = 0.
  - Required: service order 0, 1, 3, then back to 0 for the next round; one rd per cycle-pair (match cycle, then read cycle).
- Input contention:
  - Stimulus: input 2 has packets for outputs 0, 1 and 3; aptr_2 = 1.
  - Required: accepts output 1 first, then output 3, then output 0.
  - Non-interleaving: only one rd_sel[2] value is active per packet.
- Backpressure:
  - Stimulus: full_in[3] asserted for 5 cycles mid-packet on 0->3.
  - Required: rd_out[0] = 0 and wr_out[3] = 0 during the stall; the lock holds; reads resume the cycle after full_in drops; the word count is preserved.
- Parallel match:
  - Stimulus: packets 0->1 and 2->3 present simultaneously.
  - Required: both accepted in the same cycle; rd_out = 0101 in the next cycle; mux_sel fields 1 = 0 and 3 = 2.
- Reset mid-packet:
  - Stimulus: assert rst during word 2 of a 4-word packet.
  - Required: rd_out, wr_out and busy_out go to 0 asynchronously; after release of rst, all pointers are 0 and matching restarts from IDLE.
